// File: rtl/gpio_irq_pkg.sv
// ============================================================================
// Module   : gpio_irq_pkg
// Purpose  : Register map, address slice and reset constants for wb_gpio_irq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_irq_pkg;

  localparam logic [2:0] REG_IN     = 3'd0;
  localparam logic [2:0] REG_OUT    = 3'd1;
  localparam logic [2:0] REG_OE     = 3'd2;
  localparam logic [2:0] REG_IEN    = 3'd3;
  localparam logic [2:0] REG_IRISE  = 3'd4;
  localparam logic [2:0] REG_IFALL  = 3'd5;
  localparam logic [2:0] REG_PEND   = 3'd6;
  localparam logic [2:0] REG_TOGGLE = 3'd7;

  localparam int ADR_LSB = 2;
  localparam int ADR_MSB = 4;

  localparam logic [31:0] RST_VAL = 32'h0000_0000;

  // Replace each enabled byte lane of old_val with the matching lane of new_val.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync_edge.sv
// ============================================================================
// Module   : gpio_sync_edge
// Purpose  : Pin synchroniser, optional debounce (GPIO_DEBOUNCE_EN), history
//            flop and post-reset edge blanking for a bank of GPIO inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_sync_edge #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] in_val,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] accepted;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Blanking also covers the debounce delay so a pin held high through
  // reset is accepted silently.
  localparam int BLANK_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES + 1;

  for (genvar p = 0; p < WIDTH; p++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic             acc_q;

    // Counter runs only while sync disagrees with the accepted value.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        acc_q <= 1'b0;
      end else if (sync[p] == acc_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        acc_q <= sync[p];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign accepted[p] = acc_q;
  end
`else
  localparam int BLANK_CYCLES = SYNC_STAGES + 1;

  logic [31:0] unused_debounce_cfg;
  assign unused_debounce_cfg = 32'(DEBOUNCE_CYCLES);
  assign accepted = sync;
`endif

  localparam int WARM_W = $clog2(BLANK_CYCLES + 1);

  logic [WARM_W-1:0] warm_q;
  logic              blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm_q <= '0;
      prev_q <= '0;
    end else begin
      if (blank) warm_q <= warm_q + 1'b1;
      prev_q <= accepted;
    end
  end

  assign blank  = (warm_q != WARM_W'(BLANK_CYCLES));
  assign in_val = accepted;
  assign rise   = accepted & ~prev_q & {WIDTH{~blank}};
  assign fall   = ~accepted & prev_q & {WIDTH{~blank}};

endmodule

`default_nettype wire

// File: rtl/wb_gpio_irq.sv
// ============================================================================
// Module   : wb_gpio_irq
// Purpose  : Wishbone GPIO bank with edge-capture pending register and level
//            interrupt. Optional input debounce via GPIO_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             intr
);

  logic [WIDTH-1:0] out_q, oe_q, ien_q, irise_q, ifall_q, pend_q;
  logic [WIDTH-1:0] in_val, rise, fall, evt;

  gpio_sync_edge #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .gpio_i (gpio_i),
    .in_val (in_val),
    .rise   (rise),
    .fall   (fall)
  );

  assign evt = (rise & irise_q) | (fall & ifall_q);

  // Gating on ~ack forces the idle cycle between back-to-back accesses.
  logic       req, wr;
  logic [2:0] reg_sel;
  assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign reg_sel = wb_adr_i[ADR_MSB:ADR_LSB];

  logic [WIDTH-1:0] rd_w;
  logic [31:0]      rd32, merged, lane_bits;
  logic [WIDTH-1:0] wr_val, bit_mask, clr_mask;

  always_comb begin
    rd_w = '0;
    case (reg_sel)
      REG_IN:    rd_w = in_val;
      REG_OUT:   rd_w = out_q;
      REG_OE:    rd_w = oe_q;
      REG_IEN:   rd_w = ien_q;
      REG_IRISE: rd_w = irise_q;
      REG_IFALL: rd_w = ifall_q;
      REG_PEND:  rd_w = pend_q;
      default:   rd_w = '0;
    endcase
    rd32 = '0;
    rd32[WIDTH-1:0] = rd_w;
  end

  // The read value doubles as the old value for a byte-lane merge.
  assign merged    = lane_merge(rd32, wb_dat_i, wb_sel_i);
  assign lane_bits = lane_merge(32'h0, wb_dat_i, wb_sel_i);
  assign wr_val    = merged[WIDTH-1:0];
  assign bit_mask  = lane_bits[WIDTH-1:0];
  assign clr_mask  = (wr && reg_sel == REG_PEND) ? bit_mask : '0;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:ADR_MSB+1], wb_adr_i[ADR_LSB-1:0], merged, lane_bits};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= RST_VAL;
      out_q    <= RST_VAL[WIDTH-1:0];
      oe_q     <= RST_VAL[WIDTH-1:0];
      ien_q    <= RST_VAL[WIDTH-1:0];
      irise_q  <= RST_VAL[WIDTH-1:0];
      ifall_q  <= RST_VAL[WIDTH-1:0];
      pend_q   <= RST_VAL[WIDTH-1:0];
      intr     <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rd32;
      if (wr) begin
        case (reg_sel)
          REG_OUT:    out_q   <= wr_val;
          REG_OE:     oe_q    <= wr_val;
          REG_IEN:    ien_q   <= wr_val;
          REG_IRISE:  irise_q <= wr_val;
          REG_IFALL:  ifall_q <= wr_val;
          REG_TOGGLE: out_q   <= out_q ^ bit_mask;
          default:    ;
        endcase
      end
      // A new event overrides a same-cycle clear.
      pend_q <= (pend_q & ~clr_mask) | evt;
      intr   <= |(pend_q & ien_q);
    end
  end

  assign gpio_o  = out_q;
  assign gpio_oe = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_gpio_irq.sv
// ============================================================================
// Module   : tb_wb_gpio_irq
// Purpose  : Scoreboard bench for wb_gpio_irq (default 8 pins, 2 sync stages).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_gpio_irq;

  localparam int WIDTH = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + 2 + 16 + 1;
`else
  localparam int LAT = 2 + 2;
`endif
  localparam int EDGE_DLY = LAT - 1;

  localparam logic [31:0] A_IN = 32'h00, A_OUT = 32'h04, A_OE = 32'h08, A_IEN = 32'h0C;
  localparam logic [31:0] A_IRISE = 32'h10, A_IFALL = 32'h14, A_PEND = 32'h18, A_TOG = 32'h1C;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]       wb_sel_i = '0;
  logic             wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_ack_o;
  logic [WIDTH-1:0] gpio_i = '0, gpio_o, gpio_oe;
  logic             intr;

  int vectors = 0;
  int miscompares = 0;

  bit          chk_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          prev_ack = 1'b0;

  wb_gpio_irq #(.WIDTH(WIDTH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .intr(intr)
  );

  always #5 clk = ~clk;

  // Monitor: every ack pops one expectation; reads also compare data.
  always @(negedge clk) begin
    if (reset) begin
      prev_ack = 1'b0;
    end else begin
      if (wb_ack_o) begin
        vectors++;
        if (prev_ack) begin
          miscompares++;
          $display("FAIL ack_width: ack high %0d cycles, required 1", 2);
        end
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack with no access pending, required none");
        end else begin
          bit          c;
          logic [31:0] e;
          string       n;
          c = chk_q.pop_front();
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (c) begin
            vectors++;
            if (wb_dat_o !== e) begin
              miscompares++;
              $display("FAIL %s: read %h, required %h", n, wb_dat_o, e);
            end
          end
        end
      end
      prev_ack = wb_ack_o;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) got = 1'b1;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack in 8 cycles, required ack");
    end
  endtask

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit chk, input logic [31:0] exp,
                      input string nm);
    @(posedge clk); #1;
    chk_q.push_back(chk); exp_q.push_back(exp); name_q.push_back(nm);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wait_ack();
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    xfer(1'b1, adr, dat, 4'hF, 1'b0, 32'h0, "write");
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
    xfer(1'b0, adr, 32'h0, 4'hF, 1'b1, exp, nm);
  endtask

  task automatic settle();
    repeat (LAT + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    check("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
    check("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
    check("rst_intr", {31'h0, intr}, 32'h0);
    reset = 1'b0;

    // Outputs, readback, toggle, lane enables, upper bits
    wr(A_OE, 32'hFF);
    wr(A_OUT, 32'hA5);
    check("gpio_oe", {24'h0, gpio_oe}, 32'hFF);
    check("gpio_o", {24'h0, gpio_o}, 32'hA5);
    rd(A_OUT, 32'h0000_00A5, "rd_out");
    wr(A_TOG, 32'h0F);
    check("gpio_o_tog", {24'h0, gpio_o}, 32'hAA);
    rd(A_TOG, 32'h0, "rd_toggle");
    rd(A_OUT, 32'hAA, "rd_out_tog");
    xfer(1'b1, A_OUT, 32'h0000_0033, 4'b0010, 1'b0, 32'h0, "write");
    check("lane_masked", {24'h0, gpio_o}, 32'hAA);
    xfer(1'b1, A_OUT, 32'h1234_5655, 4'b0001, 1'b0, 32'h0, "write");
    check("lane0_write", {24'h0, gpio_o}, 32'h55);
    wr(A_OE, 32'hFFFF_FF00);
    rd(A_OE, 32'h0, "rd_oe_upper");
    rd(A_IN, 32'h0, "rd_in_low");

    // Rising edge on pin 0 and its interrupt latency
    wr(A_IEN, 32'h01);
    wr(A_IRISE, 32'h01);
    @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("intr_early", {31'h0, intr}, 32'h0);
    @(posedge clk); #1;
    check("intr_latency", {31'h0, intr}, 32'h1);
    rd(A_PEND, 32'h01, "pend_rise0");
    rd(A_IN, 32'h01, "rd_in_pin0");
    gpio_i[0] = 1'b0;
    settle();
    rd(A_PEND, 32'h01, "pend_no_fall0");
    check("intr_held", {31'h0, intr}, 32'h1);

    // Capture with IEN=0, then enable
    wr(A_PEND, 32'h01);
    wr(A_IEN, 32'h00);
    wr(A_IFALL, 32'h02);
    gpio_i[1] = 1'b1;
    settle();
    gpio_i[1] = 1'b0;
    settle();
    rd(A_PEND, 32'h02, "pend_fall1");
    check("intr_masked", {31'h0, intr}, 32'h0);
    wr(A_IEN, 32'h02);
    check("intr_ien_pre", {31'h0, intr}, 32'h0);
    @(posedge clk); #1;
    check("intr_ien_post", {31'h0, intr}, 32'h1);

    // W1C colliding with a new event
    wr(A_IEN, 32'h03);
    wr(A_PEND, 32'h02);
    gpio_i[0] = 1'b1;
    settle();
    rd(A_PEND, 32'h01, "pend_rise0_b");
    gpio_i[0] = 1'b0;
    settle();
    @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    repeat (EDGE_DLY - 2) @(posedge clk);
    #1;
    wr(A_PEND, 32'h01);
    check("intr_collide", {31'h0, intr}, 32'h1);
    @(posedge clk); #1;
    check("intr_collide_n1", {31'h0, intr}, 32'h1);
    rd(A_PEND, 32'h01, "pend_event_wins");
    wr(A_PEND, 32'h01);
    @(posedge clk); #1;
    check("intr_cleared", {31'h0, intr}, 32'h0);
    rd(A_PEND, 32'h00, "pend_cleared");

    // Pins high through reset, IRISE written on the first cycle out of reset
    @(posedge clk); #1;
    reset = 1'b1;
    gpio_i = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst2_gpio_o", {24'h0, gpio_o}, 32'h0);
    chk_q.push_back(1'b0); exp_q.push_back(32'h0); name_q.push_back("write");
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = A_IRISE; wb_dat_i = 32'hFF; wb_sel_i = 4'hF;
    reset = 1'b0;
    wait_ack();
    wr(A_IEN, 32'hFF);
    settle();
    rd(A_PEND, 32'h00, "pend_no_spurious");
    check("intr_no_spurious", {31'h0, intr}, 32'h0);
    rd(A_OUT, 32'h00, "rd_out_after_rst");

`ifdef GPIO_DEBOUNCE_EN
    wr(A_IFALL, 32'h08);
    repeat (30) @(posedge clk);
    #1;
    gpio_i[3] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    gpio_i[3] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rd(A_PEND, 32'h00, "glitch_ignored");
    gpio_i[3] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    gpio_i[3] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    rd(A_PEND, 32'h08, "pulse_captured");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
